vga_rx: RTL

VGA_RX -- requirements
Module: vga_rx

---
 rtl/vga_rx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/vga_rx.sv
// VGA timing receiver: recovers line/frame structure from HS/VS, locks onto a stable
// timing and emits active-area pixels with coordinates, SOF/EOL markers and measurements.
module vga_rx #(
   parameter int HSYNC_BITS  = 11,
   parameter int VSYNC_BITS  = 11,
   parameter int HD          = 1280,
   parameter int VD          = 1024,
   parameter int H_ACT_START = 360,
   parameter int V_ACT_START = 41
) (
   input  logic                  clk_i,
   input  logic                  arstn_i,
   input  logic                  VGA_HS_i,
   input  logic                  VGA_VS_i,
   input  logic [11:0]           RGB_i,
   output logic                  pix_valid_o,
   output logic [10:0]           pix_x_o,
   output logic [10:0]           pix_y_o,
   output logic [11:0]           pix_rgb_o,
   output logic                  sof_o,
   output logic                  eol_o,
   output logic                  locked_o,
   output logic [HSYNC_BITS-1:0] line_len_o,
   output logic [VSYNC_BITS-1:0] frame_lines_o
);

   localparam int H_END_I  = H_ACT_START + HD;
   localparam int H_LAST_I = H_END_I - 1;
   localparam int V_END_I  = V_ACT_START + VD;

   localparam logic [HSYNC_BITS-1:0] H_LO   = H_ACT_START[HSYNC_BITS-1:0];
   localparam logic [HSYNC_BITS-1:0] H_HI   = H_END_I[HSYNC_BITS-1:0];
   localparam logic [HSYNC_BITS-1:0] H_LAST = H_LAST_I[HSYNC_BITS-1:0];
   localparam logic [HSYNC_BITS-1:0] H_ONE  = {{(HSYNC_BITS-1){1'b0}}, 1'b1};
   localparam logic [VSYNC_BITS-1:0] V_LO   = V_ACT_START[VSYNC_BITS-1:0];
   localparam logic [VSYNC_BITS-1:0] V_HI   = V_END_I[VSYNC_BITS-1:0];
   localparam logic [VSYNC_BITS-1:0] V_ONE  = {{(VSYNC_BITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_SEARCH, S_CHECK, S_LOCKED} lockState_t;

   lockState_t              r_state;
   lockState_t              w_stateNext;
   logic                    r_hs, r_hsPrev, r_vs, r_vsPrev, r_vsPend;
   logic [11:0]             r_rgb;
   logic [HSYNC_BITS-1:0]   r_pos, r_refLen;
   logic                    r_refValid;
   logic [VSYNC_BITS-1:0]   r_line;

   logic                    w_hsFall, w_vsFall, w_frameStart, w_posSat, w_active, w_validNext;
   logic                    w_refLoad, w_refClear;
   logic [HSYNC_BITS-1:0]   w_posInc, w_pos, w_newLen, w_x;
   logic [VSYNC_BITS-1:0]   w_lineInc, w_line, w_newFrames, w_y;

   // Position and line of the sample currently held in r_hs/r_vs/r_rgb
   assign w_hsFall     = r_hsPrev & ~r_hs;
   assign w_vsFall     = r_vsPrev & ~r_vs;
   assign w_frameStart = w_hsFall & (r_vsPend | w_vsFall);
   assign w_posInc     = (r_pos == '1) ? r_pos : r_pos + H_ONE;
   assign w_pos        = w_hsFall ? '0 : w_posInc;
   assign w_posSat     = (w_pos == '1);
   assign w_lineInc    = (r_line == '1) ? r_line : r_line + V_ONE;
   assign w_line       = w_frameStart ? '0 : (w_hsFall ? w_lineInc : r_line);
   assign w_newLen     = r_pos + H_ONE;
   assign w_newFrames  = r_line + V_ONE;
   assign w_active     = (w_pos >= H_LO) && (w_pos < H_HI) && (w_line >= V_LO) && (w_line < V_HI);
   assign w_x          = w_pos - H_LO;
   assign w_y          = w_line - V_LO;
   assign w_validNext  = w_active && (w_stateNext == S_LOCKED);

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_hs       <= 1'b0;
         r_hsPrev   <= 1'b0;
         r_vs       <= 1'b0;
         r_vsPrev   <= 1'b0;
         r_rgb      <= '0;
         r_pos      <= '0;
         r_line     <= '0;
         r_vsPend   <= 1'b0;
         r_refLen   <= '0;
         r_refValid <= 1'b0;
         r_state    <= S_SEARCH;
      end else begin
         r_hs     <= VGA_HS_i;
         r_hsPrev <= r_hs;
         r_vs     <= VGA_VS_i;
         r_vsPrev <= r_vs;
         r_rgb    <= RGB_i;
         r_pos    <= w_pos;
         r_line   <= w_line;
         r_state  <= w_stateNext;
         if (w_frameStart)
            r_vsPend <= 1'b0;
         else if (w_vsFall)
            r_vsPend <= 1'b1;
         if (w_refClear)
            r_refValid <= 1'b0;
         else if (w_refLoad) begin
            r_refLen   <= w_newLen;
            r_refValid <= 1'b1;
         end
      end
   end

   // The reference length is the length of line 0 of the frame under check
   always_comb begin
      w_stateNext = r_state;
      w_refLoad   = 1'b0;
      w_refClear  = 1'b0;
      case (r_state)
         S_SEARCH: begin
            if (w_frameStart) begin
               w_stateNext = S_CHECK;
               w_refClear  = 1'b1;
            end
         end
         S_CHECK: begin
            if (w_posSat)
               w_stateNext = S_SEARCH;
            else if (w_frameStart) begin
               if (r_refValid && (w_newLen == r_refLen) && (r_refLen >= H_HI) && (w_newFrames >= V_HI))
                  w_stateNext = S_LOCKED;
               else if (r_refValid && (w_newLen != r_refLen))
                  w_stateNext = S_SEARCH;
               else
                  w_refClear = 1'b1;
            end else if (w_hsFall) begin
               if (!r_refValid)
                  w_refLoad = 1'b1;
               else if (w_newLen != r_refLen)
                  w_stateNext = S_SEARCH;
            end
         end
         S_LOCKED: begin
            if (w_posSat || (w_hsFall && (w_newLen != r_refLen)) ||
                (w_frameStart && (w_newFrames != frame_lines_o)))
               w_stateNext = S_SEARCH;
         end
         default: w_stateNext = S_SEARCH;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         pix_valid_o   <= 1'b0;
         pix_x_o       <= '0;
         pix_y_o       <= '0;
         pix_rgb_o     <= '0;
         sof_o         <= 1'b0;
         eol_o         <= 1'b0;
         locked_o      <= 1'b0;
         line_len_o    <= '0;
         frame_lines_o <= '0;
      end else begin
         pix_valid_o <= w_validNext;
         sof_o       <= w_validNext && (w_pos == H_LO) && (w_line == V_LO);
         eol_o       <= w_validNext && (w_pos == H_LAST);
         locked_o    <= (w_stateNext == S_LOCKED);
         if (w_validNext) begin
            pix_x_o   <= 11'(w_x);
            pix_y_o   <= 11'(w_y);
            pix_rgb_o <= r_rgb;
         end
         if (w_hsFall)
            line_len_o <= w_newLen;
         if (w_frameStart)
            frame_lines_o <= w_newFrames;
      end
   end

endmodule
